// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared constants, state/fault encodings and pattern helpers for the lamp monitor
package traffic_pkg;

    // Bit positions within the {R1,Y1,G1,R2,Y2,G2} lights vector
    localparam int R1 = 5;
    localparam int Y1 = 4;
    localparam int G1 = 3;
    localparam int R2 = 2;
    localparam int Y2 = 1;
    localparam int G2 = 0;

    localparam logic [5:0] ALL_RED = 6'b100100;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_ILLEGAL = 2'b01,
        FC_SHORT   = 2'b10,
        FC_TIMEOUT = 2'b11
    } fault_code_e;

    function automatic logic is_one_hot3(input logic [2:0] g);
        return (g == 3'b100) || (g == 3'b010) || (g == 3'b001);
    endfunction

    // Both road groups one-hot, and at least one of the two roads showing red
    function automatic logic is_legal(input logic [5:0] l);
        return is_one_hot3({l[R1], l[Y1], l[G1]}) &&
               is_one_hot3({l[R2], l[Y2], l[G2]}) &&
               ((l[R1] && !l[Y1] && !l[G1]) || (l[R2] && !l[Y2] && !l[G2]));
    endfunction

    // Flashing amber on both roads, all other lamps dark
    function automatic logic [5:0] flash_pattern(input logic b);
        return {1'b0, b, 1'b0, 1'b0, b, 1'b0};
    endfunction

endpackage

// File: rtl/traffic_lamp_monitor_if.sv
// rtl/traffic_lamp_monitor_if.sv - lights input and lamp/fault status bundle
// Ports: lights (FSM pattern in), lamp_out (lamp drive), fault, fault_code, phase_cnt.
// master = traffic FSM / environment side, slave = monitor side.
interface traffic_lamp_monitor_if #(
    parameter int CNT_W = 7
);
    logic [5:0]       lights;
    logic [5:0]       lamp_out;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] phase_cnt;

    modport master (output lights, input lamp_out, input fault, input fault_code, input phase_cnt);
    modport slave  (input lights, output lamp_out, output fault, output fault_code, output phase_cnt);
endinterface

// File: rtl/traffic_blink_gen.sv
// rtl/traffic_blink_gen.sv - restartable modulo-DIV counter producing the fault flash toggle
// Ports: clk, clr (sync reset), restart (load blink=1, count=0), en (count),
//        blink (current flash level), toggle_due (blink inverts at the next enabled edge).
module traffic_blink_gen #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    input  logic en,
    output logic blink,
    output logic toggle_due
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;

    assign toggle_due = (cnt_q == CW'(DIV - 1));
    assign blink      = blink_q;

    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (restart) begin
            cnt_d   = '0;
            blink_d = 1'b1;
        end else if (en) begin
            if (toggle_due) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end
endmodule

// File: rtl/traffic_lamp_monitor.sv
// rtl/traffic_lamp_monitor.sv - legality and phase-duration safety stage in front of the lamp drivers
// Ports: clk, clr (sync active-high reset), bus (slave: lights in; lamp_out, fault,
//        fault_code, phase_cnt out).
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter  int MIN_PHASE = 4,
    parameter  int MAX_PHASE = 64,
    parameter  int BLINK_DIV = 8,
    localparam int CNT_W     = $clog2(MAX_PHASE + 2)
) (
    input  logic                  clk,
    input  logic                  clr,
    traffic_lamp_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_PHASE + 1);
    localparam logic [CNT_W-1:0] CNT_MIN   = CNT_W'(MIN_PHASE);

    logic [5:0]       lights_q, lights_d;
    logic [5:0]       prev_q, prev_d;
    logic [5:0]       lamp_q, lamp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    fault_code_e      code_q, code_d;
    state_e           state_q, state_d;

    fault_code_e      raise;
    logic [CNT_W-1:0] cnt_inc;
    logic             blink, toggle_due;
    logic             blink_restart, blink_en;

    // Restart the flash on the entry edge so the first flashed frame is always lit
    assign blink_restart = (state_q != FAULT) && (state_d == FAULT);
    assign blink_en      = (state_q == FAULT);

    traffic_blink_gen #(.DIV(BLINK_DIV)) u_blink (
        .clk       (clk),
        .clr       (clr),
        .restart   (blink_restart),
        .en        (blink_en),
        .blink     (blink),
        .toggle_due(toggle_due)
    );

    always_comb begin
        lights_d = bus.lights;
        prev_d   = prev_q;
        lamp_d   = lamp_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        code_d   = code_q;
        state_d  = state_q;
        raise    = FC_NONE;
        cnt_inc  = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                lamp_d = ALL_RED;
                if (is_legal(lights_q)) begin
                    state_d = RUN;
                    prev_d  = lights_q;
                    cnt_d   = CNT_W'(1);
                end
            end
            RUN: begin
                lamp_d = lights_q;
                if (!is_legal(lights_q)) begin
                    raise = FC_ILLEGAL;
                end else if (lights_q == prev_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LIMIT) begin
                        raise = FC_TIMEOUT;
                    end
                end else if (cnt_q < CNT_MIN) begin
                    raise = FC_SHORT;
                end else begin
                    prev_d = lights_q;
                    cnt_d  = CNT_W'(1);
                end
                // The offending pattern is replaced by the first lit flash frame
                if (raise != FC_NONE) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    code_d  = raise;
                    lamp_d  = flash_pattern(1'b1);
                end
            end
            FAULT: begin
                // Registered lamp tracks the blink level it will hold after this edge
                lamp_d = flash_pattern(toggle_due ? ~blink : blink);
            end
            default: begin
                state_d = IDLE;
                lamp_d  = ALL_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // The input register is left free-running so the pattern present during
        // reset is already sampled when IDLE starts looking for a legal one
        lights_q <= lights_d;
        if (clr) begin
            state_q <= IDLE;
            prev_q  <= ALL_RED;
            lamp_q  <= ALL_RED;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            lamp_q  <= lamp_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign bus.lamp_out   = lamp_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;
    assign bus.phase_cnt  = cnt_q;
endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// tb/tb_traffic_lamp_monitor.sv - directed self-checking bench for traffic_lamp_monitor
module tb_traffic_lamp_monitor;
    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    traffic_lamp_monitor_if #(.CNT_W(7)) bus ();

    traffic_lamp_monitor #(.MIN_PHASE(4), .MAX_PHASE(64), .BLINK_DIV(8)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [5:0] l);
        bus.lights = l;
        @(posedge clk);
        #1;
    endtask

    // Reset with an illegal pattern on the input so IDLE waits for the first real phase
    task automatic do_reset();
        clr = 1'b1;
        cyc(6'b000000);
        cyc(6'b000000);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        cyc(6'b000000);
        cyc(6'b000000);
        n_total++;
        if (bus.lamp_out !== 6'b100100) $display("FAIL reset_lamp got %b want 100100", bus.lamp_out);
        else n_pass++;
        n_total++;
        if (bus.fault !== 1'b0) $display("FAIL reset_fault got %b want 0", bus.fault);
        else n_pass++;
        n_total++;
        if (bus.fault_code !== 2'b00) $display("FAIL reset_code got %b want 00", bus.fault_code);
        else n_pass++;
        n_total++;
        if (bus.phase_cnt !== 7'd0) $display("FAIL reset_cnt got %0d want 0", bus.phase_cnt);
        else n_pass++;
        clr = 1'b0;
    endtask

    task automatic test_normal();
        logic [5:0] p [1:28];
        for (int k = 1; k <= 28; k++) begin
            if (k <= 10)      p[k] = 6'b100001;
            else if (k <= 14) p[k] = 6'b100010;
            else if (k <= 24) p[k] = 6'b001100;
            else              p[k] = 6'b010100;
        end
        for (int k = 1; k <= 28; k++) begin
            cyc(p[k]);
            if (k == 2) begin
                n_total++;
                if (bus.lamp_out !== 6'b100100) $display("FAIL normal_idle_lamp got %b want 100100", bus.lamp_out);
                else n_pass++;
            end else if (k >= 3) begin
                n_total++;
                if (bus.lamp_out !== p[k-1]) $display("FAIL normal_lamp cyc %0d got %b want %b", k, bus.lamp_out, p[k-1]);
                else n_pass++;
            end
            n_total++;
            if (bus.fault !== 1'b0) $display("FAIL normal_fault cyc %0d got %b want 0", k, bus.fault);
            else n_pass++;
        end
    endtask

    // Continues directly from test_normal: 010100 has been held 4 samples
    task automatic test_illegal();
        cyc(6'b001001);
        n_total++;
        if (bus.fault !== 1'b0 || bus.lamp_out !== 6'b010100)
            $display("FAIL illegal_pre got fault=%b lamp=%b want 0 010100", bus.fault, bus.lamp_out);
        else n_pass++;
        cyc(6'b001001);
        n_total++;
        if (bus.fault !== 1'b1 || bus.fault_code !== 2'b01 || bus.lamp_out !== 6'b010010)
            $display("FAIL illegal_entry got %b %b %b want 1 01 010010", bus.fault, bus.fault_code, bus.lamp_out);
        else n_pass++;
        for (int i = 1; i <= 7; i++) begin
            cyc(6'b001001);
            n_total++;
            if (bus.lamp_out !== 6'b010010) $display("FAIL illegal_flash_on %0d got %b want 010010", i, bus.lamp_out);
            else n_pass++;
        end
        cyc(6'b100001);
        n_total++;
        if (bus.lamp_out !== 6'b000000) $display("FAIL illegal_flash_off got %b want 000000", bus.lamp_out);
        else n_pass++;
        n_total++;
        if (bus.fault !== 1'b1 || bus.fault_code !== 2'b01)
            $display("FAIL illegal_sticky got %b %b want 1 01", bus.fault, bus.fault_code);
        else n_pass++;
    endtask

    task automatic test_short_phase();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(6'b100001);
        cyc(6'b100010);
        n_total++;
        if (bus.fault !== 1'b0) $display("FAIL short_pre got %b want 0", bus.fault);
        else n_pass++;
        cyc(6'b100010);
        n_total++;
        if (bus.fault !== 1'b1 || bus.fault_code !== 2'b10)
            $display("FAIL short_x3 got %b %b want 1 10", bus.fault, bus.fault_code);
        else n_pass++;

        do_reset();
        for (int i = 0; i < 4; i++) cyc(6'b100001);
        cyc(6'b100010);
        cyc(6'b100010);
        n_total++;
        if (bus.fault !== 1'b0 || bus.phase_cnt !== 7'd1)
            $display("FAIL short_x4 got fault=%b cnt=%0d want 0 1", bus.fault, bus.phase_cnt);
        else n_pass++;
        cyc(6'b100010);
        n_total++;
        if (bus.lamp_out !== 6'b100010 || bus.phase_cnt !== 7'd2)
            $display("FAIL short_x4_run got lamp=%b cnt=%0d want 100010 2", bus.lamp_out, bus.phase_cnt);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 64; i++) cyc(6'b100001);
        cyc(6'b100010);
        n_total++;
        if (bus.fault !== 1'b0 || bus.phase_cnt !== 7'd64)
            $display("FAIL max_hold got fault=%b cnt=%0d want 0 64", bus.fault, bus.phase_cnt);
        else n_pass++;
        cyc(6'b100010);
        n_total++;
        if (bus.fault !== 1'b0 || bus.phase_cnt !== 7'd1)
            $display("FAIL max_change got fault=%b cnt=%0d want 0 1", bus.fault, bus.phase_cnt);
        else n_pass++;

        do_reset();
        for (int i = 0; i < 65; i++) cyc(6'b100001);
        n_total++;
        if (bus.fault !== 1'b0 || bus.phase_cnt !== 7'd64)
            $display("FAIL timeout_pre got fault=%b cnt=%0d want 0 64", bus.fault, bus.phase_cnt);
        else n_pass++;
        cyc(6'b100001);
        n_total++;
        if (bus.fault !== 1'b1 || bus.fault_code !== 2'b11 || bus.phase_cnt !== 7'd65)
            $display("FAIL timeout got %b %b cnt=%0d want 1 11 65", bus.fault, bus.fault_code, bus.phase_cnt);
        else n_pass++;
        n_total++;
        if (bus.lamp_out !== 6'b010010) $display("FAIL timeout_lamp got %b want 010010", bus.lamp_out);
        else n_pass++;
    endtask

    // Starts from the timeout fault left by test_timeout
    task automatic test_clr_in_fault();
        clr = 1'b1;
        cyc(6'b100001);
        clr = 1'b0;
        n_total++;
        if (bus.lamp_out !== 6'b100100 || bus.fault !== 1'b0 || bus.fault_code !== 2'b00 || bus.phase_cnt !== 7'd0)
            $display("FAIL clr_fault got %b %b %b %0d want 100100 0 00 0",
                     bus.lamp_out, bus.fault, bus.fault_code, bus.phase_cnt);
        else n_pass++;
        cyc(6'b100001);
        n_total++;
        if (bus.lamp_out !== 6'b100100) $display("FAIL clr_idle_lamp got %b want 100100", bus.lamp_out);
        else n_pass++;
        cyc(6'b100001);
        n_total++;
        if (bus.lamp_out !== 6'b100001 || bus.fault !== 1'b0 || bus.phase_cnt !== 7'd2)
            $display("FAIL clr_resume got lamp=%b fault=%b cnt=%0d want 100001 0 2",
                     bus.lamp_out, bus.fault, bus.phase_cnt);
        else n_pass++;
    endtask

    initial begin
        bus.lights = 6'b000000;
        test_reset();
        test_normal();
        test_illegal();
        test_short_phase();
        test_timeout();
        test_clr_in_fault();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
